uart_tx_ctrl: RTL and testbench
===============================

// Module: uart_tx_ctrl
// PURPOSE
//  Sequencer for the UART transmit datapath: accepts a byte via a one-cycle valid strobe and
//  walks the frame states (idle, start, 8 data bits LSB-first, stop, cleanup) with baud timing.
//  Drives state and bit index into the TX bit-select mux, which produces the serial line.
//  One frame in flight; no queue. Sits between the host/config logic and the TX pin.
// PARAMETERS
//  CLKS_PER_BIT  87  clock cycles per serial bit (87 = 10 MHz / 115200); legal range >= 2
// PORTS
//  i_Clock        in   1   single clock; all state updates on rising edge
//  i_Rst_n        in   1   synchronous, active-low reset
//  i_Tx_DV        in   1   byte valid strobe; sampled only in s_IDLE
//  i_Tx_Byte      in   8   byte to send; captured on accepting edge
//  o_State        out  state_t  current frame state (uart_tx_pkg::state_t)
//  o_Bit_Index    out  3   index of data bit being sent (0..7)
//  o_Tx_Serial    out  1   serial line, idle high
//  o_Tx_Active    out  1   high during start, data and stop bits
//  o_Tx_Done      out  1   one-cycle pulse at frame end
// BEHAVIOUR
//  Reset (i_Rst_n low at edge, any state): o_State=s_IDLE, counter=0, o_Bit_Index=0,
//   latched byte=0, o_Tx_Active=0, o_Tx_Done=0, o_Tx_Serial=1. Mid-frame reset aborts frame.
//   The next frame starts with a full start bit.
//  Baud counter: width $clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1 in every bit state.
//   The bit ends on the edge where count==CLKS_PER_BIT-1. Count clears to 0 on every state
//   or bit change.
//  s_IDLE: line high. If i_Tx_DV=1 at edge: latch i_Tx_Byte, go to s_TX_START_BIT,
//   assert o_Tx_Active. Otherwise stay.
//  s_TX_START_BIT: line 0 for CLKS_PER_BIT cycles, then go to s_TX_DATA_BITS with index 0.
//  s_TX_DATA_BITS: line = latched[o_Bit_Index]. Each bit lasts CLKS_PER_BIT cycles.
//   At end of bit: if index<7, index+1 and stay; if index==7, index wraps to 0 and go to
//   s_TX_STOP_BIT.
//  s_TX_STOP_BIT: line 1 for CLKS_PER_BIT cycles. At end: o_Tx_Active=0, o_Tx_Done=1,
//   go to s_CLEANUP.
//  s_CLEANUP: exactly one cycle, line 1, o_Tx_Done=1. Next edge: o_Tx_Done=0, go to s_IDLE.
//  Unreachable/illegal state encoding: go to s_IDLE on next edge with outputs at reset values.
//  Latency: the DV accepting edge starts the start bit. o_Tx_Done is high in cycle
//   10*CLKS_PER_BIT+1 after that edge. Earliest next accept is 10*CLKS_PER_BIT+2 edges
//   after the first.
//  i_Tx_DV outside s_IDLE is ignored (dropped, not queued). i_Tx_Byte changes mid-frame
//   have no effect.
//  DV held high continuously: back-to-back frames, each separated by exactly the one
//   cleanup cycle plus one idle cycle.
//  All outputs are registered except o_Tx_Serial, which is combinational from
//   o_State/o_Bit_Index/latched byte via the mux.
// STRUCTURE
//  uart_tx_pkg holds:
//   - typedef enum logic [2:0] state_t {s_IDLE, s_TX_START_BIT, s_TX_DATA_BITS,
//     s_TX_STOP_BIT, s_CLEANUP}
//   - localparam DATA_BITS=8
//  Sub-module: uart_tx_mux_1, one instance. Inputs: o_State, latched byte, o_Bit_Index.
//   Output drives o_Tx_Serial.
//  FSM, baud counter, bit index and byte latch all live in this module.
// TESTING (CLKS_PER_BIT=4 unless stated)
//  1 Reset: hold i_Rst_n=0 5 cycles, DV=1 -> o_State=s_IDLE, o_Tx_Serial=1,
//    Active=0, Done=0 throughout.
//  2 Send 0xA5: line = 0,1,0,1,0,0,1,0,1,1 (start, LSB-first, stop), each held exactly
//    4 cycles. Done pulses 1 cycle at cycle 41. Active high 40 cycles.
//  3 DV pulses at cycles 3, 20, 38 after accepting 0x3C, with i_Tx_Byte changed to 0xFF
//    -> only 0x3C sent; no second frame starts.
//  4 DV held high, bytes 0x00 then 0xFF -> two frames. Gap between stop bit and next
//    start bit = 2 cycles (cleanup + idle).
//  5 Deassert i_Rst_n for 1 cycle during data bit 3 of 0x55 -> s_IDLE next edge, line 1,
//    no Done. A following DV sends a complete frame.
//  6 CLKS_PER_BIT=2, byte 0x80 -> bit 7 high for 2 cycles. Done at cycle 21.
//    Counter never exceeds 1.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared types for the UART transmit sequencer: frame state encoding and data width.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        s_IDLE         = 3'd0,
        s_TX_START_BIT = 3'd1,
        s_TX_DATA_BITS = 3'd2,
        s_TX_STOP_BIT  = 3'd3,
        s_CLEANUP      = 3'd4
    } state_t;

    localparam int DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Host-side bundle for the UART transmit sequencer: byte strobe in, frame status out.
interface uart_tx_ctrl_if;
    import uart_tx_pkg::*;

    // i_Tx_DV is a one-cycle valid strobe with no ready: it is accepted only on an edge where
    // o_State is s_IDLE and silently dropped otherwise; i_Tx_Byte is captured on that same edge.
    logic                 i_Tx_DV;
    logic [DATA_BITS-1:0] i_Tx_Byte;
    state_t               o_State;
    logic [2:0]           o_Bit_Index;
    logic                 o_Tx_Serial;
    logic                 o_Tx_Active;
    logic                 o_Tx_Done;

    modport master (
        output i_Tx_DV, i_Tx_Byte,
        input  o_State, o_Bit_Index, o_Tx_Serial, o_Tx_Active, o_Tx_Done
    );

    modport slave (
        input  i_Tx_DV, i_Tx_Byte,
        output o_State, o_Bit_Index, o_Tx_Serial, o_Tx_Active, o_Tx_Done
    );

endinterface

// File: rtl/uart_tx_mux_1.sv
// Bit-select mux: turns frame state, bit index and latched byte into the serial line level.
module uart_tx_mux_1
    import uart_tx_pkg::*;
(
    input  state_t               state,
    input  logic [DATA_BITS-1:0] data,
    input  logic [2:0]           bit_index,
    output logic                 serial
);

    always_comb begin
        serial = 1'b1;
        case (state)
            s_TX_START_BIT: serial = 1'b0;
            s_TX_DATA_BITS: serial = data[bit_index];
            default:        serial = 1'b1;
        endcase
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: accepts one byte per frame and walks start, 8 data bits (LSB first),
// stop and a one-cycle cleanup, each serial bit lasting CLKS_PER_BIT clocks.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic           i_Clock,
    input  logic           i_Rst_n,
    uart_tx_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    state_t               state;
    logic [CNT_W-1:0]     count;
    logic [2:0]           bit_index;
    logic [DATA_BITS-1:0] data_q;
    logic                 active;
    logic                 done;
    logic                 bit_end;

    assign bit_end = (count == LAST_CNT);

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            state     <= s_IDLE;
            count     <= '0;
            bit_index <= '0;
            data_q    <= '0;
            active    <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                s_IDLE: begin
                    count     <= '0;
                    bit_index <= '0;
                    done      <= 1'b0;
                    if (bus.i_Tx_DV) begin
                        data_q <= bus.i_Tx_Byte;
                        active <= 1'b1;
                        state  <= s_TX_START_BIT;
                    end
                end
                s_TX_START_BIT: begin
                    if (bit_end) begin
                        count     <= '0;
                        bit_index <= '0;
                        state     <= s_TX_DATA_BITS;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                s_TX_DATA_BITS: begin
                    if (bit_end) begin
                        count <= '0;
                        if (bit_index == LAST_BIT) begin
                            bit_index <= '0;
                            state     <= s_TX_STOP_BIT;
                        end else begin
                            bit_index <= bit_index + 3'd1;
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                s_TX_STOP_BIT: begin
                    if (bit_end) begin
                        count  <= '0;
                        active <= 1'b0;
                        done   <= 1'b1;
                        state  <= s_CLEANUP;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                s_CLEANUP: begin
                    count <= '0;
                    done  <= 1'b0;
                    state <= s_IDLE;
                end
                // Illegal encodings recover to idle with everything at its reset value.
                default: begin
                    state     <= s_IDLE;
                    count     <= '0;
                    bit_index <= '0;
                    data_q    <= '0;
                    active    <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

    uart_tx_mux_1 u_mux (
        .state     (state),
        .data      (data_q),
        .bit_index (bit_index),
        .serial    (bus.o_Tx_Serial)
    );

    assign bus.o_State     = state;
    assign bus.o_Bit_Index = bit_index;
    assign bus.o_Tx_Active = active;
    assign bus.o_Tx_Done   = done;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: lane 0 runs CLKS_PER_BIT=4, lane 1 runs CLKS_PER_BIT=2.
module tb_uart_tx_ctrl;
    import uart_tx_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n [2];
    logic       dv [2];
    logic [7:0] tx_byte [2];
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;

    // bit 8 set marks a frame expected to be cut short by reset
    logic [8:0] exp_q0[$];
    logic [8:0] exp_q1[$];
    int         start0_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push_exp(int lane, logic [8:0] v);
        if (lane == 0) exp_q0.push_back(v);
        else exp_q1.push_back(v);
    endfunction

    // ---------------- DUTs and monitors ----------------
    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int C  = (g == 0) ? 4 : 2;
        localparam int NS = 10 * C;

        uart_tx_ctrl_if bus ();
        assign bus.i_Tx_DV   = dv[g];
        assign bus.i_Tx_Byte = tx_byte[g];

        uart_tx_ctrl #(.CLKS_PER_BIT(C)) dut (
            .i_Clock (clk),
            .i_Rst_n (rst_n[g]),
            .bus     (bus)
        );

        logic       samp [NS];
        int         n;
        logic       ok;
        logic [7:0] rx;
        logic [8:0] obs;
        logic [8:0] expv;

        initial begin
            forever begin
                @(negedge clk);
                if (!bus.o_Tx_Active) begin
                    chk("idle_done", int'(bus.o_Tx_Done), 0);
                end else begin
                    if (g == 0) start0_q.push_back(cyc);
                    n = 0;
                    while (bus.o_Tx_Active && n < NS) begin
                        samp[n] = bus.o_Tx_Serial;
                        n++;
                        @(negedge clk);
                    end
                    if (n < NS) begin
                        chk("abort_state", int'(bus.o_State), int'(s_IDLE));
                        chk("abort_line", int'(bus.o_Tx_Serial), 1);
                        chk("abort_done", int'(bus.o_Tx_Done), 0);
                        obs = 9'h100;
                    end else begin
                        chk("active_len", int'(bus.o_Tx_Active), 0);
                        chk("done_pulse", int'(bus.o_Tx_Done), 1);
                        chk("cleanup_state", int'(bus.o_State), int'(s_CLEANUP));
                        chk("cleanup_line", int'(bus.o_Tx_Serial), 1);
                        ok = 1'b1;
                        for (int b = 0; b < 10; b++)
                            for (int k = 1; k < C; k++)
                                if (samp[b*C+k] != samp[b*C]) ok = 1'b0;
                        chk("bit_width", int'(ok), 1);
                        chk("start_bit", int'(samp[0]), 0);
                        chk("stop_bit", int'(samp[9*C]), 1);
                        for (int i = 0; i < 8; i++) rx[i] = samp[(i+1)*C];
                        obs = {1'b0, rx};
                        @(negedge clk);
                        chk("done_clear", int'(bus.o_Tx_Done), 0);
                        chk("post_state", int'(bus.o_State), int'(s_IDLE));
                    end
                    if ((g == 0 && exp_q0.size() == 0) || (g == 1 && exp_q1.size() == 0)) begin
                        chk("frame_expected", int'(obs), 9'h1FF);
                    end else begin
                        if (g == 0) expv = exp_q0.pop_front();
                        else expv = exp_q1.pop_front();
                        chk("frame", int'(obs), int'(expv));
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(int lane, logic [7:0] b);
        dv[lane]      = 1'b1;
        tx_byte[lane] = b;
        @(negedge clk);
        dv[lane] = 1'b0;
    endtask

    task automatic idle(int k);
        repeat (k) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    int pulse_at [3] = '{3, 20, 38};
    int pos;

    initial begin
        rst_n   = '{1'b0, 1'b0};
        dv      = '{1'b1, 1'b1};
        tx_byte = '{8'hEE, 8'hEE};

        // reset held with DV asserted
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_state", int'(g_lane[0].bus.o_State), int'(s_IDLE));
            chk("rst_line", int'(g_lane[0].bus.o_Tx_Serial), 1);
            chk("rst_active", int'(g_lane[0].bus.o_Tx_Active), 0);
            chk("rst_done", int'(g_lane[0].bus.o_Tx_Done), 0);
        end
        rst_n = '{1'b1, 1'b1};
        dv    = '{1'b0, 1'b0};
        idle(2);

        // single frame 0xA5
        push_exp(0, 9'h0A5);
        send(0, 8'hA5);
        idle(50);

        // DV strobes mid-frame with a changed byte are dropped
        push_exp(0, 9'h03C);
        dv[0]      = 1'b1;
        tx_byte[0] = 8'h3C;
        @(negedge clk);
        dv[0]      = 1'b0;
        tx_byte[0] = 8'hFF;
        pos = 0;
        foreach (pulse_at[i]) begin
            idle(pulse_at[i] - 1 - pos);
            dv[0] = 1'b1;
            @(negedge clk);
            dv[0] = 1'b0;
            pos = pulse_at[i];
        end
        idle(60);

        // DV held high: back-to-back frames
        start0_q.delete();
        push_exp(0, 9'h000);
        push_exp(0, 9'h0FF);
        dv[0]      = 1'b1;
        tx_byte[0] = 8'h00;
        @(negedge clk);
        tx_byte[0] = 8'hFF;
        idle(42);
        dv[0] = 1'b0;
        idle(50);
        if (start0_q.size() >= 2) chk("frame_gap", start0_q[1] - start0_q[0], 42);
        else chk("frame_count", start0_q.size(), 2);

        // reset during data bit 3 of 0x55, then a clean frame
        push_exp(0, 9'h100);
        send(0, 8'h55);
        idle(17);
        rst_n[0] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b1;
        chk("abort_idle", int'(g_lane[0].bus.o_State), int'(s_IDLE));
        idle(3);
        push_exp(0, 9'h055);
        send(0, 8'h55);
        idle(50);

        // short bit time on lane 1
        push_exp(1, 9'h080);
        send(1, 8'h80);
        idle(30);

        chk("queue0_drained", exp_q0.size(), 0);
        chk("queue1_drained", exp_q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
